// File: rtl/ps2_line_buffer.sv
// ps2_line_buffer
//   Collects decoded PS/2 keystrokes into a line of up to MAX_CHARS
//   characters. Handles backspace, commits the line on enter, and holds
//   the committed line until the consumer acknowledges it.
//
// Ports
//   clock            system clock, all state updates on its rising edge
//   reset            synchronous active-high reset
//   ascii_char       character code, valid when key_pressed rises
//   key_pressed      key level; each 0->1 transition is one keystroke
//   line_ack         consumer acknowledge, releases a held line
//   ps2_line_content packed line, char k at [LINE_W-1-CHAR_W*k -: CHAR_W]
//   ps2_line_length  number of valid characters
//   ps2_line_ready   high while a committed line is held
//   overflow         sticky: a character was dropped from this line

// One character slot. Clear wins over write.
module ps2_line_slot #(
  parameter int CHAR_W = 8
) (
  input  logic              clock,
  input  logic              clr,
  input  logic              wr,
  input  logic [CHAR_W-1:0] d,
  output logic [CHAR_W-1:0] q
);
  always_ff @(posedge clock) begin
    if (clr)     q <= '0;
    else if (wr) q <= d;
  end
endmodule

module ps2_line_buffer #(
  parameter int MAX_CHARS = 32,
  parameter int CHAR_W    = 8,
  localparam int LINE_W   = CHAR_W * MAX_CHARS,
  localparam int LEN_W    = $clog2(MAX_CHARS + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CHAR_W-1:0] ascii_char,
  input  logic              key_pressed,
  input  logic              line_ack,
  output logic [LINE_W-1:0] ps2_line_content,
  output logic [LEN_W-1:0]  ps2_line_length,
  output logic              ps2_line_ready,
  output logic              overflow
);

  typedef enum logic {COLLECT, HOLD} state_t;

  state_t                          state_q, state_d;
  logic                            key_q;
  logic [LEN_W-1:0]                count_q;
  logic                            ovf_q;
  logic [MAX_CHARS-1:0][CHAR_W-1:0] slot_q;

  logic key_evt, is_print, is_bs, is_enter, full, empty;
  logic push, pop, drop, flush;

  // Registered copy resets high so a level already high after reset is
  // not mistaken for a fresh keystroke.
  always_ff @(posedge clock) begin
    if (reset) key_q <= 1'b1;
    else       key_q <= key_pressed;
  end

  assign key_evt  = key_pressed & ~key_q;
  assign is_print = (ascii_char >= CHAR_W'(8'h20)) && (ascii_char <= CHAR_W'(8'h7E));
  assign is_bs    = (ascii_char == CHAR_W'(8'h08));
  assign is_enter = (ascii_char == CHAR_W'(8'h0D));
  assign full     = (count_q == LEN_W'(MAX_CHARS));
  assign empty    = (count_q == '0);

  always_ff @(posedge clock) begin
    if (reset) state_q <= COLLECT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    pop     = 1'b0;
    drop    = 1'b0;
    flush   = 1'b0;
    case (state_q)
      COLLECT: begin
        if (key_evt) begin
          if (is_print) begin
            if (!full) push = 1'b1;
            else       drop = 1'b1;
          end else if (is_bs) begin
            if (!empty) pop = 1'b1;
          end else if (is_enter) begin
            if (!empty) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Any keystroke coinciding with the ack is simply not looked at.
        if (line_ack) begin
          flush   = 1'b1;
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || flush) count_q <= '0;
    else if (push)      count_q <= count_q + LEN_W'(1);
    else if (pop)       count_q <= count_q - LEN_W'(1);
  end

  always_ff @(posedge clock) begin
    if (reset || flush) ovf_q <= 1'b0;
    else if (drop)      ovf_q <= 1'b1;
  end

  // Slot i is written by a push when count==i and zeroed by a backspace
  // when count==i+1, which keeps every slot at or above count at zero.
  for (genvar i = 0; i < MAX_CHARS; i++) begin : g_slot
    logic slot_clr, slot_wr;
    assign slot_wr  = push && (count_q == LEN_W'(i));
    assign slot_clr = reset || flush || (pop && (count_q == LEN_W'(i + 1)));

    ps2_line_slot #(.CHAR_W(CHAR_W)) u_slot (
      .clock (clock),
      .clr   (slot_clr),
      .wr    (slot_wr),
      .d     (ascii_char),
      .q     (slot_q[i])
    );

    assign ps2_line_content[LINE_W-1-CHAR_W*i -: CHAR_W] = slot_q[i];
  end

  assign ps2_line_length = count_q;
  assign ps2_line_ready  = (state_q == HOLD);
  assign overflow        = ovf_q;

endmodule

// File: doc/ps2_line_buffer.md
PS2_LINE_BUFFER -- requirements
Module: ps2_line_buffer

Interface
REQ-001 Parameter MAX_CHARS, default 32: maximum characters per line, at least 2.
REQ-002 Parameter CHAR_W, default 8: bits per character; LINE_W = CHAR_W*MAX_CHARS; LEN_W = clog2(MAX_CHARS+1).
REQ-003 clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 ascii_char  in  CHAR_W  character code; valid in the cycle key_pressed rises.
REQ-006 key_pressed  in  1  level from the keyboard decoder; each 0->1 transition is one keystroke.
REQ-007 line_ack  in  1  consumer acknowledge; a 1 while line_ready=1 releases the line.
REQ-008 ps2_line_content  out  LINE_W  packed line; char k at bits [LINE_W-1-CHAR_W*k -: CHAR_W], MSB-first.
REQ-009 ps2_line_length  out  LEN_W  number of valid characters in ps2_line_content.
REQ-010 ps2_line_ready  out  1  high while a committed line is held.
REQ-011 overflow  out  1  sticky; at least one character was dropped from the current line.

Function
REQ-012 A keystroke is detected in cycle N when key_pressed=1 and its registered copy from cycle N-1 is 0; a held level yields exactly one keystroke.
REQ-013 The registered copy of key_pressed resets to 1; a level already high out of reset is not a keystroke.
REQ-014 FSM has two states: COLLECT (accepting keys) and HOLD (line committed, awaiting line_ack).
REQ-015 In COLLECT, printable keystroke (0x20..0x7E) with count<MAX_CHARS: write to slot count, increment count; visible in cycle N+1.
REQ-016 In COLLECT, printable keystroke with count=MAX_CHARS: character dropped, count unchanged, overflow=1 from N+1.
REQ-017 In COLLECT, backspace (0x08) with count>0: decrement count, clear slot count-1 to 0; overflow unchanged.
REQ-018 Backspace with count=0 is ignored.
REQ-019 In COLLECT, enter (0x0D) with count>0: go to HOLD, ps2_line_ready=1 from N+1; content and length frozen.
REQ-020 Enter with count=0 is ignored; empty lines are never committed.
REQ-021 All other codes are ignored in every state.
REQ-022 Unused slots (index >= count) always read as 0.
REQ-023 In HOLD, all keystrokes are dropped and do not set overflow.
REQ-024 In HOLD, line_ack=1 in cycle M: next cycle content=0, length=0, ps2_line_ready=0, overflow=0, state COLLECT.
REQ-025 A keystroke in the same cycle as the accepting line_ack is dropped; the first accepted key is at M+1 or later.
REQ-026 line_ack in COLLECT has no effect.
REQ-027 ps2_line_length always equals the internal count; it never exceeds MAX_CHARS and never wraps.

Reset
REQ-028 With reset=1 at a clock edge, the next cycle has ps2_line_content=0, ps2_line_length=0, ps2_line_ready=0, overflow=0, state COLLECT, key_pressed copy=1.
REQ-029 Reset takes priority over every keystroke and over line_ack, in any state.
REQ-030 Reset during HOLD discards the committed line.

Verification
REQ-031 Keys 'H'(0x48), 'I'(0x49), enter -> ps2_line_ready=1, length=2, content[LINE_W-1 -: 16]=0x4849, rest 0; stays high until line_ack.
REQ-032 MAX_CHARS=4; 6 printable keys, then enter -> length=4, first 4 chars kept, overflow=1; after line_ack overflow=0.
REQ-033 'A', 'B', backspace, backspace, backspace, 'C', enter -> length=1, content top byte=0x43, no overflow.
REQ-034 Enter on empty line; then key_pressed held high 10 cycles with 'Z' -> no ready on enter, exactly one 'Z' stored.
REQ-035 In HOLD, key 'Q' on the same cycle as line_ack, then 'R' -> new line contains only 'R' (length=1).
REQ-036 Reset asserted mid-line (count=3) and in HOLD -> all outputs 0 next cycle; following keys start at slot 0.
